// File: rtl/ahb_pkg.sv
// Shared definitions for the LSU-to-AHB bridge.
//   - bus widths (32-bit address and data)
//   - FSM state encoding
//   - RWTYP field position inside haddr (bits 29:27)
//   - address window: only addr[31:16] == 0 is reachable over AHB
//   - rwtyp access-size encodings
package ahb_pkg;

  localparam int AHB_ADDR_WIDTH = 32;
  localparam int AHB_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WDATA,
    S_RESP
  } state_t;

  localparam int RWTYP_MSB = 29;
  localparam int RWTYP_LSB = 27;

  // Any bit set under this mask puts the address outside the bus window.
  localparam logic [AHB_ADDR_WIDTH-1:0] WIN_MASK = 32'hFFFF_0000;

  localparam logic [2:0] RW_BYTE = 3'b000;
  localparam logic [2:0] RW_HALF = 3'b001;
  localparam logic [2:0] RW_WORD = 3'b010;

  function automatic logic in_window(input logic [AHB_ADDR_WIDTH-1:0] addr);
    return (addr & WIN_MASK) == '0;
  endfunction

  // haddr = {2'b0, rwtyp, 11'b0, addr[15:0]}
  function automatic logic [AHB_ADDR_WIDTH-1:0] make_haddr(input logic [2:0]  rwtyp,
                                                           input logic [15:0] addr);
    logic [AHB_ADDR_WIDTH-1:0] a;
    a                     = '0;
    a[RWTYP_MSB:RWTYP_LSB] = rwtyp;
    a[15:0]               = addr;
    return a;
  endfunction

endpackage

// File: rtl/ahb_wdt.sv
// WAIT-state watchdog for lsu2ahb.
//   clk, rstn : clock, async active-low reset
//   clr       : zero the count (asserted on the cycle before WAIT is entered)
//   en        : one stalled WAIT cycle (WAIT && !hready)
//   expired   : high during the TIMEOUT_CYCLES-th stalled cycle, so the FSM
//               leaves WAIT on the edge that closes that cycle
module ahb_wdt #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lsu2ahb.sv
// LSU request -> single AHB transfer bridge, one transaction in flight.
//   req_*   : valid/ready request (we, rwtyp, addr, wdata), accepted in IDLE
//   resp_*  : one-cycle resp_valid with err flag and read data (held)
//   h*      : AHB master side; hsel pulses one cycle per transfer, hresp ignored
// Flow: IDLE -> ISSUE -> WAIT (until hready) -> WDATA -> RESP -> IDLE.
// Out-of-window addresses go straight IDLE -> RESP with resp_err.
// Optional: define LSU2AHB_TIMEOUT_EN to bound WAIT to TIMEOUT_CYCLES stalled
// cycles (ahb_wdt); otherwise WAIT waits for hready forever.
module lsu2ahb
  import ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_rwtyp,
  input  logic [AHB_ADDR_WIDTH-1:0] req_addr,
  input  logic [AHB_DATA_WIDTH-1:0] req_wdata,
  output logic                      resp_valid,
  output logic                      resp_err,
  output logic [AHB_DATA_WIDTH-1:0] resp_rdata,
  output logic                      hsel,
  output logic                      hwrite,
  output logic [AHB_ADDR_WIDTH-1:0] haddr,
  output logic [AHB_DATA_WIDTH-1:0] hwdata,
  input  logic                      hready,
  input  logic                      hresp,
  input  logic [AHB_DATA_WIDTH-1:0] hrdata
);

  state_t                    state, nxt;
  logic                      lat_we;
  logic [2:0]                lat_rwtyp;
  logic [15:0]               lat_addr;
  logic [AHB_DATA_WIDTH-1:0] lat_wdata;
  logic [AHB_DATA_WIDTH-1:0] rd_cap;
  logic                      accept;
  logic                      timeout;
  logic                      unused_ok;

  assign accept = req_valid && (state == S_IDLE);

`ifdef LSU2AHB_TIMEOUT_EN
  logic wdt_clr, wdt_en;
  assign wdt_clr = (state == S_ISSUE);
  assign wdt_en  = (state == S_WAIT) && !hready;

  ahb_wdt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdt (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (wdt_clr),
    .en      (wdt_en),
    .expired (timeout)
  );
  assign unused_ok = hresp;
`else
  assign timeout   = 1'b0;
  assign unused_ok = ^{hresp, TIMEOUT_CYCLES};
`endif

  // Reads also pass through the WDATA slot (driving zero) so that reads and
  // writes complete with the same latency.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (accept) nxt = in_window(req_addr) ? S_ISSUE : S_RESP;
      S_ISSUE: nxt = S_WAIT;
      S_WAIT:  if (hready)       nxt = S_WDATA;
               else if (timeout) nxt = S_RESP;
      S_WDATA: nxt = S_RESP;
      S_RESP:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      lat_we     <= 1'b0;
      lat_rwtyp  <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rd_cap     <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_rwtyp <= req_rwtyp;
        lat_addr  <= req_addr[15:0];
        lat_wdata <= req_wdata;
      end
      if (state == S_WAIT && hready && !lat_we) rd_cap <= hrdata;
      // Response fields change only on entry to RESP and hold until the next one.
      if (accept && !in_window(req_addr)) begin
        resp_err   <= 1'b1;
        resp_rdata <= '0;
      end else if (state == S_WAIT && timeout) begin
        resp_err   <= 1'b1;
        resp_rdata <= '0;
      end else if (state == S_WDATA) begin
        resp_err   <= 1'b0;
        resp_rdata <= lat_we ? '0 : rd_cap;
      end
    end
  end

  // Bus outputs decode straight from state so async reset clears them at once.
  logic bus_act;
  assign bus_act    = (state == S_ISSUE) || (state == S_WAIT) || (state == S_WDATA);
  assign req_ready  = (state == S_IDLE);
  assign hsel       = (state == S_ISSUE);
  assign hwrite     = bus_act && lat_we;
  assign haddr      = bus_act ? make_haddr(lat_rwtyp, lat_addr) : '0;
  assign hwdata     = (state == S_WDATA && lat_we) ? lat_wdata : '0;
  assign resp_valid = (state == S_RESP);

endmodule

// File: tb/tb_lsu2ahb.sv
// Self-checking bench for lsu2ahb: directed write/read-back, out-of-window,
// back-to-back requests, random traffic against a word-memory reference,
// async reset mid-transaction and (with LSU2AHB_TIMEOUT_EN) WAIT timeout.
module tb_lsu2ahb;
  import ahb_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_rwtyp;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic        hready, hresp;
  logic [31:0] hrdata;

  lsu2ahb #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_rwtyp(req_rwtyp), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .hsel(hsel), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [31:0] ref_mem   [256];  // what the LSU side expects memory to hold
  logic [31:0] slave_mem [256];  // what the bus slave actually stores

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_hsel"},  hsel, 0);
    chk({tag, "_haddr"}, haddr, 0);
    chk({tag, "_hwdata"}, hwdata, 0);
    chk({tag, "_rvld"},  resp_valid, 0);
  endtask

  // One complete transaction. Called and returns at a negedge in IDLE.
  // Expected cycle k after the acceptance edge: 1 ISSUE, then WAIT for
  // stalls+1 cycles, then the data slot, then RESP; out-of-window: RESP at k=1.
  task automatic run_txn(input logic we, input logic [2:0] rw, input logic [31:0] addr,
                         input logic [31:0] wd, input int stalls);
    logic [31:0] ea, er;
    logic        err, to;
    int          idx, nwait;
    idx = int'(addr[9:2]);
    err = (addr >> 16) != 0;
    to  = 1'b0;
`ifdef LSU2AHB_TIMEOUT_EN
    to  = !err && (stalls >= TMO);
`endif
    nwait = to ? TMO : stalls + 1;
    ea = err ? 32'h0 : ((32'(rw) << 27) | (addr & 32'h0000_FFFF));
    er = (err || to || we) ? 32'h0 : ref_mem[idx];

    chk("pre_ready", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_rwtyp = rw; req_addr = addr; req_wdata = wd;
    hready = 1'($urandom); hresp = 1'($urandom); hrdata = $urandom;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    if (err) begin
      chk("oow_rvld", resp_valid, 1);
      chk("oow_err",  resp_err, 1);
      chk("oow_rdata", resp_rdata, 0);
      chk("oow_hsel", hsel, 0);
      chk("oow_haddr", haddr, 0);
    end else begin
      chk("iss_hsel",  hsel, 1);
      chk("iss_haddr", haddr, ea);
      chk("iss_hwrite", hwrite, 32'(we));
      chk("iss_rvld",  resp_valid, 0);
      chk("iss_ready", req_ready, 0);
      hready = 1'($urandom); hresp = 1'($urandom);
      for (int w = 0; w < nwait; w++) begin
        @(negedge clk);
        chk("wait_hsel",  hsel, 0);
        chk("wait_haddr", haddr, ea);
        chk("wait_hwdata", hwdata, 0);
        chk("wait_rvld",  resp_valid, 0);
        hready = !to && (w == stalls);
        hresp  = 1'($urandom);
        hrdata = hready ? slave_mem[idx] : $urandom;
      end
      if (!to) begin
        @(negedge clk);
        chk("dat_hsel",   hsel, 0);
        chk("dat_haddr",  haddr, ea);
        chk("dat_hwdata", hwdata, we ? wd : 32'h0);
        chk("dat_rvld",   resp_valid, 0);
        if (we) slave_mem[idx] = hwdata;
        hready = 1'($urandom); hrdata = $urandom;
      end
      @(negedge clk);
      chk("rsp_rvld",  resp_valid, 1);
      chk("rsp_err",   resp_err, 32'(to));
      chk("rsp_rdata", resp_rdata, er);
      chk("rsp_hsel",  hsel, 0);
      chk("rsp_haddr", haddr, 0);
    end
    if (we && !err && !to) ref_mem[idx] = wd;
    @(negedge clk);
    chk_idle("post");
    chk("hold_rdata", resp_rdata, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, v;
    int          hs[$];
    int          nresp;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      slave_mem[i] = v;
    end
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_rwtyp = '0;
    req_addr = '0; req_wdata = '0; hready = 1'b0; hresp = 1'b0; hrdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk_idle("rst");
    chk("rst_err", resp_err, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_hwrite", hwrite, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed: write then read back, out-of-window.
    run_txn(1'b1, RW_WORD, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    run_txn(1'b0, RW_WORD, 32'h0000_0010, 32'h0, 0);
    chk("readback", resp_rdata, 32'hDEAD_BEEF);
    run_txn(1'b0, RW_BYTE, 32'h0001_0000, 32'h1234_5678, 0);

    // req_valid held high across three reads.
    hs.delete(); nresp = 0;
    req_valid = 1'b1; req_we = 1'b0; req_rwtyp = RW_HALF; req_addr = 32'h0000_0010;
    hready = 1'b1; hrdata = slave_mem[4];
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (hsel) hs.push_back(c);
      if (resp_valid) begin
        nresp++;
        chk("b2b_rdata", resp_rdata, ref_mem[4]);
        if (nresp == 3) break;
      end
    end
    req_valid = 1'b0;
    chk("b2b_resp", nresp, 3);
    chk("b2b_hsel", hs.size(), 3);
    if (hs.size() == 3) begin
      chk("b2b_gap0", hs[1] - hs[0], 5);
      chk("b2b_gap1", hs[2] - hs[1], 5);
    end
    @(negedge clk);
    chk_idle("b2b_end");

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      logic        we;
      logic [2:0]  rw;
      we = 1'($urandom);
      rw = 3'($urandom);
      a  = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 65535)) << 16);
      run_txn(we, rw, a, $urandom, $urandom_range(0, 3));
    end

    // Async reset during ISSUE (p=1) and during WAIT (p=2).
    for (int p = 1; p <= 2; p++) begin
      req_valid = 1'b1; req_we = 1'b0; req_rwtyp = 3'b011; req_addr = 32'h0000_0044;
      hready = 1'b0;
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        req_valid = 1'b0;
      end
      chk("pre_rst_haddr", haddr, 32'h1800_0044);
      #2 rstn = 1'b0;
      #1;
      chk_idle("arst");
      chk("arst_err", resp_err, 0);
      chk("arst_rdata", resp_rdata, 0);
      chk("arst_hwrite", hwrite, 0);
      @(negedge clk);
      rstn = 1'b1; hready = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        chk_idle("post_rst");
      end
    end

`ifdef LSU2AHB_TIMEOUT_EN
    // hready tied low: error response after TMO stalled WAIT cycles.
    run_txn(1'b0, RW_WORD, 32'h0000_0020, 32'h0, 40);
    run_txn(1'b1, RW_WORD, 32'h0000_0024, 32'hCAFE_F00D, 40);
    run_txn(1'b0, RW_WORD, 32'h0000_0024, 32'h0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
